// File: rtl/rob_commit.sv
// Reorder buffer: in-order allocation, CDB write-back, operand forwarding and
// registered in-order retirement into the register file commit port.
// Tags are 1-based (tag = index + 1); tag 0 means "no producer".
module rob_commit #(
  parameter int unsigned ROB_SIZE = 16,
  parameter int unsigned ROB_LEN  = 4,
  parameter int unsigned DATA_LEN = 32,
  parameter int unsigned REG_LEN  = 5
) (
  input  logic                clk,
  input  logic                rst,
  // dispatcher allocation
  input  logic                ena_from_dsp,
  input  logic [REG_LEN-1:0]  rd_from_dsp,
  output logic [ROB_LEN:0]    Q_to_dsp,
  output logic                full_to_dsp,
  // operand forwarding queries
  input  logic [ROB_LEN:0]    Q1_from_dsp,
  input  logic [ROB_LEN:0]    Q2_from_dsp,
  output logic                ready1_to_dsp,
  output logic                ready2_to_dsp,
  output logic [DATA_LEN-1:0] V1_to_dsp,
  output logic [DATA_LEN-1:0] V2_to_dsp,
  // common data bus
  input  logic                cdb_flag,
  input  logic [ROB_LEN:0]    cdb_Q,
  input  logic [DATA_LEN-1:0] cdb_V,
  // misprediction recovery
  input  logic                flush,
  // register file commit port
  output logic                commit_flag_to_rf,
  output logic [REG_LEN-1:0]  rd_to_rf,
  output logic [ROB_LEN:0]    Q_to_rf,
  output logic [DATA_LEN-1:0] V_to_rf
);

  localparam logic [ROB_LEN:0] FullCount = (ROB_LEN + 1)'(ROB_SIZE);

  // Entry state
  logic [ROB_SIZE-1:0] busy_q, busy_d;
  logic [ROB_SIZE-1:0] ready_q, ready_d;
  logic [REG_LEN-1:0]  rd_q  [ROB_SIZE];
  logic [REG_LEN-1:0]  rd_d  [ROB_SIZE];
  logic [DATA_LEN-1:0] val_q [ROB_SIZE];
  logic [DATA_LEN-1:0] val_d [ROB_SIZE];

  // Pointers and occupancy
  logic [ROB_LEN-1:0] head_q, head_d;
  logic [ROB_LEN-1:0] tail_q, tail_d;
  logic [ROB_LEN:0]   count_q, count_d;

  // Registered commit port
  logic                commit_flag_q, commit_flag_d;
  logic [REG_LEN-1:0]  rd_rf_q, rd_rf_d;
  logic [ROB_LEN:0]    q_rf_q, q_rf_d;
  logic [DATA_LEN-1:0] v_rf_q, v_rf_d;

  logic               full;
  logic               alloc_take;
  logic               wb_take;
  logic               commit_take;
  logic [ROB_LEN-1:0] cdb_idx;
  logic [ROB_LEN-1:0] idx1;
  logic [ROB_LEN-1:0] idx2;

  // Tag-to-index conversion drops the 1-based offset; tag 0 is filtered separately.
  assign cdb_idx = cdb_Q[ROB_LEN-1:0] - 1'b1;
  assign idx1    = Q1_from_dsp[ROB_LEN-1:0] - 1'b1;
  assign idx2    = Q2_from_dsp[ROB_LEN-1:0] - 1'b1;

  assign full        = (count_q == FullCount);
  assign alloc_take  = ena_from_dsp && !full;
  assign wb_take     = cdb_flag && (cdb_Q != '0) && busy_q[cdb_idx];
  assign commit_take = (count_q != '0) && ready_q[head_q];

  assign Q_to_dsp          = {1'b0, tail_q} + 1'b1;
  assign full_to_dsp       = full;
  assign commit_flag_to_rf = commit_flag_q;
  assign rd_to_rf          = rd_rf_q;
  assign Q_to_rf           = q_rf_q;
  assign V_to_rf           = v_rf_q;

  // Next-state: allocate at tail, write back from CDB, retire head; flush wins over all.
  always_comb begin
    busy_d        = busy_q;
    ready_d       = ready_q;
    rd_d          = rd_q;
    val_d         = val_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    commit_flag_d = 1'b0;
    rd_rf_d       = rd_rf_q;
    q_rf_d        = q_rf_q;
    v_rf_d        = v_rf_q;

    if (flush) begin
      busy_d  = '0;
      ready_d = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (alloc_take) begin
        busy_d[tail_q]  = 1'b1;
        ready_d[tail_q] = 1'b0;
        rd_d[tail_q]    = rd_from_dsp;
        val_d[tail_q]   = '0;
        tail_d          = tail_q + 1'b1;
      end
      if (wb_take) begin
        ready_d[cdb_idx] = 1'b1;
        val_d[cdb_idx]   = cdb_V;
      end
      if (commit_take) begin
        busy_d[head_q] = 1'b0;
        head_d         = head_q + 1'b1;
        // x0 retires without a write strobe
        commit_flag_d  = (rd_q[head_q] != '0);
        rd_rf_d        = rd_q[head_q];
        q_rf_d         = {1'b0, head_q} + 1'b1;
        v_rf_d         = val_q[head_q];
      end
      unique case ({alloc_take, commit_take})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Operand 1 forwarding: CDB bypass first, then the stored entry.
  always_comb begin
    ready1_to_dsp = 1'b0;
    V1_to_dsp     = '0;
    if (Q1_from_dsp != '0) begin
      if (cdb_flag && (cdb_Q == Q1_from_dsp)) begin
        ready1_to_dsp = 1'b1;
        V1_to_dsp     = cdb_V;
      end else if (ready_q[idx1]) begin
        ready1_to_dsp = 1'b1;
        V1_to_dsp     = val_q[idx1];
      end
    end
  end

  // Operand 2 forwarding: CDB bypass first, then the stored entry.
  always_comb begin
    ready2_to_dsp = 1'b0;
    V2_to_dsp     = '0;
    if (Q2_from_dsp != '0) begin
      if (cdb_flag && (cdb_Q == Q2_from_dsp)) begin
        ready2_to_dsp = 1'b1;
        V2_to_dsp     = cdb_V;
      end else if (ready_q[idx2]) begin
        ready2_to_dsp = 1'b1;
        V2_to_dsp     = val_q[idx2];
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q        <= '0;
      ready_q       <= '0;
      rd_q          <= '{default: '0};
      val_q         <= '{default: '0};
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      commit_flag_q <= 1'b0;
      rd_rf_q       <= '0;
      q_rf_q        <= '0;
      v_rf_q        <= '0;
    end else begin
      busy_q        <= busy_d;
      ready_q       <= ready_d;
      rd_q          <= rd_d;
      val_q         <= val_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      commit_flag_q <= commit_flag_d;
      rd_rf_q       <= rd_rf_d;
      q_rf_q        <= q_rf_d;
      v_rf_q        <= v_rf_d;
    end
  end

endmodule

// File: tb/tb_rob_commit.sv
// Directed bench for rob_commit: expected retirements are queued with the cycle
// in which the commit port must show them, and every cycle is checked.
module tb_rob_commit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic [4:0]  rd_in;
  logic [4:0]  q_to_dsp;
  logic        full;
  logic [4:0]  q1, q2;
  logic        ready1, ready2;
  logic [31:0] v1, v2;
  logic        cdb_flag;
  logic [4:0]  cdb_q;
  logic [31:0] cdb_v;
  logic        flush;
  logic        commit_flag;
  logic [4:0]  rd_rf;
  logic [4:0]  q_rf;
  logic [31:0] v_rf;

  typedef struct {
    int          due;
    logic [4:0]  rd;
    logic [4:0]  q;
    logic [31:0] v;
  } exp_t;

  exp_t sb[$];
  int   cyc        = 0;
  int   vectors    = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  rob_commit dut (
    .clk               (clk),
    .rst               (rst),
    .ena_from_dsp      (ena),
    .rd_from_dsp       (rd_in),
    .Q_to_dsp          (q_to_dsp),
    .full_to_dsp       (full),
    .Q1_from_dsp       (q1),
    .Q2_from_dsp       (q2),
    .ready1_to_dsp     (ready1),
    .ready2_to_dsp     (ready2),
    .V1_to_dsp         (v1),
    .V2_to_dsp         (v2),
    .cdb_flag          (cdb_flag),
    .cdb_Q             (cdb_q),
    .cdb_V             (cdb_v),
    .flush             (flush),
    .commit_flag_to_rf (commit_flag),
    .rd_to_rf          (rd_rf),
    .Q_to_rf           (q_rf),
    .V_to_rf           (v_rf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, sample 1 time unit later and check the commit port.
  task automatic step();
    exp_t e;
    @(posedge clk);
    cyc++;
    #1;
    if (sb.size() != 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      chk("commit_flag", 32'(commit_flag), (e.rd != 5'd0) ? 32'd1 : 32'd0);
      if (e.rd != 5'd0) begin
        chk("commit_rd", 32'(rd_rf), 32'(e.rd));
        chk("commit_q", 32'(q_rf), 32'(e.q));
        chk("commit_v", v_rf, e.v);
      end
    end else begin
      chk("no_commit", 32'(commit_flag), 32'd0);
    end
  endtask

  task automatic push(input int due, input logic [4:0] rd, input logic [4:0] q,
                      input logic [31:0] v);
    exp_t e;
    e.due = due;
    e.rd  = rd;
    e.q   = q;
    e.v   = v;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic alloc(input logic [4:0] rd);
    ena   = 1'b1;
    rd_in = rd;
    step();
    ena   = 1'b0;
  endtask

  // Broadcast on the CDB for one edge.
  task automatic cdb(input logic [4:0] q, input logic [31:0] v);
    cdb_flag = 1'b1;
    cdb_q    = q;
    cdb_v    = v;
    step();
    cdb_flag = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; ena = 1'b0; rd_in = '0; q1 = '0; q2 = '0;
    cdb_flag = 1'b0; cdb_q = '0; cdb_v = '0; flush = 1'b0;

    // Reset state
    step();
    chk("rst_q_to_dsp", 32'(q_to_dsp), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_rd_rf", 32'(rd_rf), 32'd0);
    chk("rst_q_rf", 32'(q_rf), 32'd0);
    chk("rst_v_rf", v_rf, 32'd0);
    chk("rst_ready1", 32'(ready1), 32'd0);
    chk("rst_v1", v1, 32'd0);
    chk("rst_ready2", 32'(ready2), 32'd0);
    chk("rst_v2", v2, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) step();

    // Single allocate / write-back / commit with latency check
    chk("t1_tag", 32'(q_to_dsp), 32'd1);
    alloc(5'd5);
    chk("t1_next_tag", 32'(q_to_dsp), 32'd2);
    q1 = 5'd1;
    #1;
    chk("t1_not_ready", 32'(ready1), 32'd0);
    push(cyc + 2, 5'd5, 5'd1, 32'h1234);
    cdb(5'd1, 32'h1234);
    chk("t1_fwd_ready", 32'(ready1), 32'd1);
    chk("t1_fwd_v", v1, 32'h1234);
    q1 = 5'd0;
    step();
    step();

    // Out-of-order write-back, in-order retirement
    do_reset();
    alloc(5'd1);
    alloc(5'd2);
    alloc(5'd3);
    push(cyc + 4, 5'd1, 5'd1, 32'h11);
    push(cyc + 5, 5'd2, 5'd2, 32'h22);
    push(cyc + 6, 5'd3, 5'd3, 32'h33);
    cdb(5'd3, 32'h33);
    cdb(5'd2, 32'h22);
    cdb(5'd1, 32'h11);
    for (int i = 0; i < 4; i++) step();

    // Fill to capacity, ignored 17th allocation, tag reuse after a commit
    do_reset();
    for (int i = 0; i < 16; i++) begin
      chk("fill_tag", 32'(q_to_dsp), 32'(i + 1));
      alloc(5'(i + 1));
    end
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_wrap_tag", 32'(q_to_dsp), 32'd1);
    alloc(5'd9);
    chk("over_full", 32'(full), 32'd1);
    chk("over_tag", 32'(q_to_dsp), 32'd1);
    push(cyc + 2, 5'd1, 5'd1, 32'hAA);
    cdb(5'd1, 32'hAA);
    step();
    chk("drain_full", 32'(full), 32'd0);
    chk("drain_tag", 32'(q_to_dsp), 32'd1);
    alloc(5'd20);
    chk("reuse_full", 32'(full), 32'd1);
    chk("reuse_tag", 32'(q_to_dsp), 32'd2);
    // Tag 16 is the newest-but-one entry; forwarding reads it once written.
    q2 = 5'd16;
    cdb(5'd16, 32'hBEEF);
    chk("wrap_fwd_ready", 32'(ready2), 32'd1);
    chk("wrap_fwd_v", v2, 32'hBEEF);
    q2 = 5'd0;

    // x0 destination retires silently, next entry retires normally
    do_reset();
    alloc(5'd0);
    alloc(5'd7);
    push(cyc + 2, 5'd0, 5'd1, 32'h5);
    cdb(5'd1, 32'h5);
    push(cyc + 2, 5'd7, 5'd2, 32'h77);
    cdb(5'd2, 32'h77);
    step();
    step();

    // Flush with busy entries and simultaneous allocate / write-back
    do_reset();
    alloc(5'd1);
    alloc(5'd2);
    alloc(5'd3);
    alloc(5'd4);
    cdb(5'd1, 32'h10);
    flush    = 1'b1;
    ena      = 1'b1;
    rd_in    = 5'd9;
    cdb_flag = 1'b1;
    cdb_q    = 5'd2;
    cdb_v    = 32'd7;
    q1       = 5'd2;
    q2       = 5'd1;
    #1;
    chk("bypass_ready", 32'(ready1), 32'd1);
    chk("bypass_v", v1, 32'd7);
    chk("stored_ready", 32'(ready2), 32'd1);
    chk("stored_v", v2, 32'h10);
    step();
    flush    = 1'b0;
    ena      = 1'b0;
    cdb_flag = 1'b0;
    #1;
    chk("flush_tag", 32'(q_to_dsp), 32'd1);
    chk("flush_full", 32'(full), 32'd0);
    chk("flush_ready_clr", 32'(ready2), 32'd0);
    q1 = 5'd0;
    q2 = 5'd0;
    // Tag 0 never forwards, even with a tag-0 broadcast present
    cdb_flag = 1'b1;
    cdb_q    = 5'd0;
    cdb_v    = 32'h55;
    #1;
    chk("tag0_ready", 32'(ready1), 32'd0);
    chk("tag0_v", v1, 32'd0);
    cdb_flag = 1'b0;
    // Write-back to a flushed (non-busy) entry must not retire anything
    cdb(5'd1, 32'h99);
    step();
    step();
    chk("post_flush_tag", 32'(q_to_dsp), 32'd1);
    alloc(5'd3);
    push(cyc + 2, 5'd3, 5'd1, 32'h42);
    cdb(5'd1, 32'h42);
    for (int i = 0; i < 3; i++) step();

    // Mid-operation reset discards a ready entry with no pulse afterwards
    alloc(5'd6);
    cdb(5'd2, 32'h66);
    do_reset();
    step();
    chk("mid_rst_tag", 32'(q_to_dsp), 32'd1);

    chk("sb_pending", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
